// File: rtl/uart_message_rx_pkg.sv
// Shared definitions for the 64-bit UART message receiver.
// Optional even-parity framing is enabled by defining UART_RX_PARITY_EN.
package uart_message_rx_pkg;

  localparam int MSG_BYTES = 8;
  localparam int BYTE_W    = 8;
  localparam int MSG_W     = MSG_BYTES * BYTE_W;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    DONE
  } rx_state_t;

  // Even-parity bit: makes the total count of ones (data + parity) even.
  function automatic logic even_parity_bit(input logic [BYTE_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line plus falling-edge detect.
// All flops reset to 1 so the idle-high line never shows a false edge.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx_async,
  output logic rx_sync,
  output logic rx_fall
);

  logic meta_p0;
  logic sync_p1;
  logic prev_p2;

  // Synchronizer chain and one extra flop to remember the previous synchronized value
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      prev_p2 <= 1'b1;
    end else begin
      meta_p0 <= rx_async;
      sync_p1 <= meta_p0;
      prev_p2 <= sync_p1;
    end
  end

  assign rx_sync = sync_p1;
  assign rx_fall = prev_p2 & ~sync_p1;

endmodule

// File: rtl/uart_message_rx.sv
// UART receiver that assembles eight 8N1 bytes into one 64-bit message.
// First byte received lands in message_out[63:56]. An idle gap longer than
// TIMEOUT_BITS bit-times inside a message discards the partial message.
// Define UART_RX_PARITY_EN for 8E1 framing with an even-parity check.
module uart_message_rx
  import uart_message_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             RX,
  output logic [MSG_W-1:0] message_out,
  output logic             message_valid,
  output logic             frame_error,
  output logic             timeout_error,
  output logic             busy
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CNT_W    = $clog2(CLKS_PER_BIT);
  localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TO_W     = $clog2(TO_LIMIT + 1);
  localparam int BCNT_W   = $clog2(MSG_BYTES);
  localparam int BIDX_W   = $clog2(BYTE_W);

  logic              rx_s;
  logic              rx_fall;

  rx_state_t         state;
  rx_state_t         state_next;

  logic [CNT_W-1:0]  clk_cnt;
  logic [BIDX_W-1:0] bit_idx;
  logic [BCNT_W-1:0] byte_cnt;
  logic [TO_W-1:0]   idle_cnt;
  logic              err_wait;

  logic [BYTE_W-1:0] shift_reg;
  logic [MSG_W-1:0]  msg_acc;

  logic              half_tick;
  logic              bit_tick;
  logic              last_bit;
  logic              last_byte;
  logic              idle_expired;

  logic              ev_byte_ok;
  logic              ev_frame_err;
  logic              ev_timeout;
  logic              ev_done;

  uart_rx_sync u_sync (
    .clk      (clk),
    .rst      (Reset),
    .rx_async (RX),
    .rx_sync  (rx_s),
    .rx_fall  (rx_fall)
  );

  assign half_tick    = (clk_cnt == CNT_W'(HALF_BIT - 1));
  assign bit_tick     = (clk_cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign last_bit     = (bit_idx == BIDX_W'(BYTE_W - 1));
  assign last_byte    = (byte_cnt == BCNT_W'(MSG_BYTES - 1));
  assign idle_expired = (byte_cnt != '0) && (idle_cnt == TO_W'(TO_LIMIT - 1));

  // State register
  always_ff @(posedge clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic and single-cycle event strobes
  always_comb begin
    state_next   = state;
    ev_byte_ok   = 1'b0;
    ev_frame_err = 1'b0;
    ev_timeout   = 1'b0;
    ev_done      = 1'b0;
    case (state)
      IDLE: begin
        // A timeout and a start edge in the same cycle both take effect.
        if (idle_expired) ev_timeout = 1'b1;
        if (rx_fall)      state_next = START;
      end
      START: begin
        // Mid-point of the start bit: high means it was only a glitch.
        if (half_tick) state_next = rx_s ? IDLE : DATA;
      end
      DATA: begin
        if (bit_tick && last_bit) begin
`ifdef UART_RX_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (bit_tick) begin
          // A bad parity bit reuses the STOP error path (wait for line high).
          if (rx_s != even_parity_bit(shift_reg)) ev_frame_err = 1'b1;
          state_next = STOP;
        end
      end
`endif
      STOP: begin
        if (err_wait) begin
          // Discarding after an error: leave only once the line is idle again.
          if (rx_s) state_next = IDLE;
        end else if (bit_tick) begin
          if (rx_s) begin
            ev_byte_ok = 1'b1;
            state_next = last_byte ? DONE : IDLE;
          end else begin
            ev_frame_err = 1'b1;
          end
        end
      end
      DONE: begin
        ev_done    = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Bit-period counter, restarted on every state change and every bit period
  always_ff @(posedge clk) begin
    if (Reset || (state_next != state) || bit_tick) clk_cnt <= '0;
    else                                            clk_cnt <= clk_cnt + CNT_W'(1);
  end

  // Data-bit index within the current byte
  always_ff @(posedge clk) begin
    if (Reset || (state != DATA)) bit_idx <= '0;
    else if (bit_tick)            bit_idx <= bit_idx + BIDX_W'(1);
  end

  // LSB-first deserializer; data path carries no reset
  always_ff @(posedge clk) begin
    if ((state == DATA) && bit_tick) shift_reg <= {rx_s, shift_reg[BYTE_W-1:1]};
  end

  // Message accumulator: each good byte shifts in at the bottom
  always_ff @(posedge clk) begin
    if (ev_byte_ok) msg_acc <= {msg_acc[MSG_W-BYTE_W-1:0], shift_reg};
  end

  // Byte counter: cleared on error, timeout or completed message
  always_ff @(posedge clk) begin
    if (Reset || ev_frame_err || ev_timeout || ev_done) byte_cnt <= '0;
    else if (ev_byte_ok)                                byte_cnt <= byte_cnt + BCNT_W'(1);
  end

  // Inter-byte idle timer, only running while a partial message is held
  always_ff @(posedge clk) begin
    if (Reset || (state != IDLE) || (byte_cnt == '0) || idle_expired) idle_cnt <= '0;
    else                                                            idle_cnt <= idle_cnt + TO_W'(1);
  end

  // Error-discard flag: set on a framing/parity error, cleared on return to IDLE
  always_ff @(posedge clk) begin
    if (Reset)                                      err_wait <= 1'b0;
    else if (ev_frame_err)                          err_wait <= 1'b1;
    else if ((state == STOP) && (state_next == IDLE)) err_wait <= 1'b0;
  end

  // Registered message output and status pulses
  always_ff @(posedge clk) begin
    if (Reset) begin
      message_out   <= '0;
      message_valid <= 1'b0;
      frame_error   <= 1'b0;
      timeout_error <= 1'b0;
    end else begin
      if (ev_done) message_out <= msg_acc;
      message_valid <= ev_done;
      frame_error   <= ev_frame_err;
      timeout_error <= ev_timeout;
    end
  end

  assign busy = (state != IDLE) || (byte_cnt != '0);

endmodule

// File: tb/tb_uart_message_rx.sv
// Directed self-checking bench for uart_message_rx (CLKS_PER_BIT=16, TIMEOUT_BITS=20).
module tb_uart_message_rx;

  localparam int CPB = 16;
  localparam int TOB = 20;

  logic        clk = 1'b0;
  logic        Reset;
  logic        RX;
  logic [63:0] message_out;
  logic        message_valid;
  logic        frame_error;
  logic        timeout_error;
  logic        busy;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  int          valid_cnt = 0;
  int          ferr_cnt  = 0;
  int          terr_cnt  = 0;
  logic [63:0] last_msg  = '0;
  int          v0, f0, t0;

`ifdef UART_RX_PARITY_EN
  bit par_err = 1'b0;
`endif

  always #5 clk = ~clk;

  uart_message_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(TOB)) dut (
    .clk           (clk),
    .Reset         (Reset),
    .RX            (RX),
    .message_out   (message_out),
    .message_valid (message_valid),
    .frame_error   (frame_error),
    .timeout_error (timeout_error),
    .busy          (busy)
  );

  // Pulse counters, sampled away from the active edge
  always @(negedge clk) begin
    if (message_valid) begin
      valid_cnt = valid_cnt + 1;
      last_msg  = message_out;
    end
    if (frame_error)   ferr_cnt = ferr_cnt + 1;
    if (timeout_error) terr_cnt = terr_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    v0 = valid_cnt;
    f0 = ferr_cnt;
    t0 = terr_cnt;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic good_stop);
    RX = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (CPB) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    RX = par_err ? ~(^b) : ^b;
    repeat (CPB) @(negedge clk);
`endif
    RX = good_stop;
    repeat (CPB) @(negedge clk);
    RX = 1'b1;
  endtask

  task automatic send_msg(input logic [63:0] m);
    for (int i = 0; i < 8; i++) send_byte(m[63-8*i -: 8], 1'b1);
  endtask

  initial begin
    Reset = 1'b1;
    RX    = 1'b1;
    repeat (4) @(negedge clk);
    check("reset_msg",   message_out,   64'h0);
    check("reset_valid", message_valid, 64'h0);
    check("reset_ferr",  frame_error,   64'h0);
    check("reset_terr",  timeout_error, 64'h0);
    check("reset_busy",  busy,          64'h0);
    Reset = 1'b0;
    repeat (10) @(negedge clk);

    // Clean message
    snap();
    send_msg(64'h0123_4567_89AB_CDEF);
    repeat (8) @(negedge clk);
    check("msg1_valid_cnt", valid_cnt - v0, 64'd1);
    check("msg1_out",       message_out,    64'h0123_4567_89AB_CDEF);
    check("msg1_at_pulse",  last_msg,       64'h0123_4567_89AB_CDEF);
    check("msg1_no_ferr",   ferr_cnt - f0,  64'd0);
    check("msg1_no_terr",   terr_cnt - t0,  64'd0);
    check("msg1_busy",      busy,           64'h0);

    // Third byte with a bad stop bit, then a clean message
    snap();
    send_byte(8'h01, 1'b1);
    send_byte(8'h23, 1'b1);
    send_byte(8'h45, 1'b0);
    repeat (32) @(negedge clk);
    check("ferr_pulse",    ferr_cnt - f0,  64'd1);
    check("ferr_no_valid", valid_cnt - v0, 64'd0);
    check("ferr_busy",     busy,           64'h0);
    check("ferr_msg_hold", message_out,    64'h0123_4567_89AB_CDEF);
    send_msg(64'h1122_3344_5566_7788);
    repeat (8) @(negedge clk);
    check("after_ferr_valid", valid_cnt - v0, 64'd1);
    check("after_ferr_msg",   message_out,    64'h1122_3344_5566_7788);

    // Four bytes then a long idle gap
    snap();
    send_byte(8'hA1, 1'b1);
    send_byte(8'hB2, 1'b1);
    send_byte(8'hC3, 1'b1);
    send_byte(8'hD4, 1'b1);
    check("partial_busy", busy, 64'h1);
    repeat (300) @(negedge clk);
    check("timeout_not_early", terr_cnt - t0, 64'd0);
    for (int i = 0; i < 60 && terr_cnt == t0; i++) @(negedge clk);
    check("timeout_pulse",    terr_cnt - t0,  64'd1);
    check("timeout_busy",     busy,           64'h0);
    check("timeout_no_valid", valid_cnt - v0, 64'd0);
    send_msg(64'hFEDC_BA98_7654_3210);
    repeat (8) @(negedge clk);
    check("after_to_valid", valid_cnt - v0, 64'd1);
    check("after_to_msg",   message_out,    64'hFEDC_BA98_7654_3210);

    // Short glitch between bytes 2 and 3 must not disturb the byte count
    snap();
    send_byte(8'h5A, 1'b1);
    send_byte(8'hC3, 1'b1);
    repeat (16) @(negedge clk);
    RX = 1'b0;
    repeat (5) @(negedge clk);
    RX = 1'b1;
    repeat (30) @(negedge clk);
    check("glitch_no_flags", (ferr_cnt - f0) + (terr_cnt - t0) + (valid_cnt - v0), 64'd0);
    check("glitch_busy",     busy, 64'h1);
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h81, 1'b1);
    send_byte(8'h7E, 1'b1);
    send_byte(8'h10, 1'b1);
    send_byte(8'h08, 1'b1);
    repeat (8) @(negedge clk);
    check("glitch_msg_valid", valid_cnt - v0, 64'd1);
    check("glitch_msg",       message_out,    64'h5AC3_00FF_817E_1008);

    // Reset in the middle of byte 5
    snap();
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'h56, 1'b1);
    send_byte(8'h78, 1'b1);
    RX = 1'b0;
    repeat (CPB) @(negedge clk);
    RX = 1'b1;
    repeat (CPB) @(negedge clk);
    RX = 1'b0;
    repeat (CPB + 5) @(negedge clk);
    Reset = 1'b1;
    RX    = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_msg",  message_out, 64'h0);
    check("midrst_busy", busy,        64'h0);
    check("midrst_flags", {61'd0, message_valid, frame_error, timeout_error}, 64'h0);
    Reset = 1'b0;
    repeat (10) @(negedge clk);
    check("midrst_no_pulses", (ferr_cnt - f0) + (terr_cnt - t0) + (valid_cnt - v0), 64'd0);
    send_msg(64'h0F1E_2D3C_4B5A_6978);
    repeat (8) @(negedge clk);
    check("after_rst_valid", valid_cnt - v0, 64'd1);
    check("after_rst_msg",   message_out,    64'h0F1E_2D3C_4B5A_6978);

`ifdef UART_RX_PARITY_EN
    // Wrong parity on 0x5A, then a correctly framed message
    snap();
    par_err = 1'b1;
    send_byte(8'h5A, 1'b1);
    par_err = 1'b0;
    repeat (32) @(negedge clk);
    check("parity_ferr",     ferr_cnt - f0,  64'd1);
    check("parity_no_valid", valid_cnt - v0, 64'd0);
    check("parity_busy",     busy,           64'h0);
    send_msg(64'h5A5A_0102_0304_A5A5);
    repeat (8) @(negedge clk);
    check("parity_ok_valid", valid_cnt - v0, 64'd1);
    check("parity_ok_msg",   message_out,    64'h5A5A_0102_0304_A5A5);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/uart_message_rx.md
UART_MESSAGE_RX -- requirements
Module: uart_message_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, meaning clock cycles per UART bit (minimum 4).
REQ-002 SHALL have parameter TIMEOUT_BITS, default 20, meaning the idle bit-times allowed between bytes of one message.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port Reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port RX, input, 1, asynchronous serial line, idle high.
REQ-006 SHALL have port message_out, output, 64, the last complete received message.
REQ-007 SHALL have port message_valid, output, 1, one-cycle pulse when message_out updates.
REQ-008 SHALL have port frame_error, output, 1, one-cycle pulse on a bad stop bit (or bad parity, see Configuration).
REQ-009 SHALL have port timeout_error, output, 1, one-cycle pulse when a partial message is discarded on inter-byte timeout.
REQ-010 SHALL have port busy, output, 1, high while any state other than IDLE is active or a partial message is held.

Function
REQ-011 SHALL pass RX through a 2-flop synchronizer; all sampling uses the synchronized value (2-cycle input latency).
REQ-012 SHALL frame each byte as 8N1: start bit 0, 8 data bits LSB first, stop bit 1.
REQ-013 SHALL implement states IDLE, START, DATA, [PARITY], STOP, DONE.
REQ-014 IDLE->START on a synchronized falling edge; START re-samples at CLKS_PER_BIT/2 cycles; low->DATA, high->IDLE (glitch, no error flag).
REQ-015 DATA SHALL sample each bit every CLKS_PER_BIT cycles after the start mid-point; 8 bits then ->STOP (or PARITY).
REQ-016 STOP sampled high SHALL store the byte; sampled low SHALL pulse frame_error, clear the byte count, discard the partial message and ->IDLE only once RX is high.
REQ-017 Byte order: first received byte SHALL land in message_out[63:56], eighth in [7:0].
REQ-018 A 3-bit byte counter SHALL count 0..7; after the eighth good stop bit ->DONE.
REQ-019 DONE SHALL last one cycle: load message_out, pulse message_valid, zero the counter, ->IDLE.
REQ-020 message_out SHALL hold its value until the next DONE; partial bytes never appear on it.
REQ-021 With byte count 1..7 in IDLE, RX high for TIMEOUT_BITS*CLKS_PER_BIT cycles SHALL pulse timeout_error and zero the counter.
REQ-022 A start edge arriving in the same cycle the timeout expires SHALL be taken as a new message start (timeout wins, then START).
REQ-023 Back-to-back frames (stop bit immediately followed by start) SHALL be received without loss.

Reset
REQ-024 Reset SHALL force IDLE, counters 0, synchronizer flops 1, message_out 64'h0, message_valid/frame_error/timeout_error 0, busy 0.
REQ-025 Reset mid-frame SHALL discard all partial data with no error pulse; reception resumes on the next falling edge after Reset deasserts.

Configuration
REQ-026 Macro UART_RX_PARITY_EN defined: frame SHALL be 8E1 with PARITY state sampling an even-parity bit; a mismatch pulses frame_error and discards the message as in REQ-016.
REQ-027 Macro UART_RX_PARITY_EN undefined: no PARITY state, no parity logic; frame is 8N1.

Structure
REQ-028 A shared package SHALL hold the state enum, MSG_BYTES=8, BYTE_W=8, and the parity-bit function.
REQ-029 Sub-module uart_rx_sync (2-flop synchronizer plus falling-edge detect) SHALL be instantiated once; everything else stays in one module.

Verification (CLKS_PER_BIT=16, TIMEOUT_BITS=20)
REQ-030 Bytes 01,23,45,67,89,AB,CD,EF sent 8N1 -> one message_valid, message_out=64'h0123_4567_89AB_CDEF, no error pulses.
REQ-031 Byte 3 sent with stop bit 0 -> frame_error pulse, no message_valid; a following clean 8-byte message decodes correctly.
REQ-032 4 bytes, then RX high 320 cycles -> timeout_error pulse on cycle 320, busy low; next message decodes correctly.
REQ-033 RX low pulse of 5 cycles in IDLE -> back to IDLE, no flags, counter unchanged.
REQ-034 Reset asserted mid-byte 5 -> all outputs at reset values; next full message decodes correctly.
REQ-035 UART_RX_PARITY_EN defined, byte 0x5A with odd parity bit -> frame_error pulse; correct parity -> normal decode.
